bcd_seq_converter: RTL and testbench

- Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Successor to the 4-bit combinational tens/units converter: arbitrary input width, configurable digit count, start/done handshake and overflow saturation.
- Feeds the calculator's display path: takes the ALU result and drives the 7-segment digit decoders.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_adj.sv | 19 +
 rtl/bcd_seq_converter.sv | 119 +++++++++++
 tb/tb_bcd_seq_converter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;
  localparam logic [3:0] DIGIT_MAX  = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit double-dabble correction: a digit of 5..9 gets 3 added before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  // Inputs are at most 9 on the adjusted path, so the 4-bit add never carries out.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADJ_THRESH) begin
      digit_o = digit_i + ADJ_ADD;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one input bit per clock)
// with start/done handshake and saturation to all-nines on overflow.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WIDTH-1:0]            binary,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   bcd,
  output logic                        overflow
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   sat_val;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign sat_val = {DIGITS{DIGIT_MAX}};

  // Next-state and datapath update for the conversion sequence.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d  = binary;
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_LOAD;
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // A set MSB after correction means the top digit was >= 5 and its carry is lost.
        {acc_d, shift_d} = {acc_adj, shift_q} << 1;
        sticky_d         = sticky_q | acc_adj[ACC_W-1];
        cnt_d            = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        bcd_d   = sticky_q ? sat_val : acc_q;
        ovf_d   = sticky_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Randomized and directed bench for bcd_seq_converter across four WIDTH/DIGITS configurations.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [15:0] bin_v;
  logic [3:0]  busy_v, done_v, ovf_v;
  logic [11:0] bcd0;
  logic [7:0]  bcd1, bcd2;
  logic [19:0] bcd3;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] prev_bcd [4];
  logic        prev_ovf [4];

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u_w8d3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .binary(bin_v[7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd0), .overflow(ovf_v[0]));
  bcd_seq_converter #(.WIDTH(4), .DIGITS(2)) u_w4d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .binary(bin_v[3:0]),
    .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd1), .overflow(ovf_v[1]));
  bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) u_w8d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .binary(bin_v[7:0]),
    .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd2), .overflow(ovf_v[2]));
  bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) u_w16d5 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .binary(bin_v),
    .busy(busy_v[3]), .done(done_v[3]), .bcd(bcd3), .overflow(ovf_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    case (sel)
      0: return 8;
      1: return 4;
      2: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int digits_of(input int sel);
    case (sel)
      0: return 3;
      1: return 2;
      2: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic logic [19:0] bcd_of(input int sel);
    case (sel)
      0: return {8'h00, bcd0};
      1: return {12'h000, bcd1};
      2: return {12'h000, bcd2};
      default: return bcd3;
    endcase
  endfunction

  function automatic int max_of(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p - 1;
  endfunction

  // Reference: decimal digits by division, or all nines when the value does not fit.
  function automatic logic [19:0] ref_bcd(input int v, input int d);
    logic [19:0] r = 20'h0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      if (v > max_of(d)) r[4*i +: 4] = 4'h9;
      else begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  // One conversion; optionally pulses start with another value at edge ign_e while busy.
  task automatic run_conv(input int sel, input int val, input int ign_e, input int ign_val);
    int w, d, done_cnt, done_e;
    logic [19:0] exp_b;
    logic exp_o;
    w = width_of(sel);
    d = digits_of(sel);
    done_cnt = 0;
    done_e = -1;
    exp_b = ref_bcd(val, d);
    exp_o = (val > max_of(d));
    @(negedge clk);
    bin_v = 16'(val);
    start_v[sel] = 1'b1;
    for (int e = 0; e <= w + 3; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("busy s%0d v%0d e%0d", sel, val, e), 32'(busy_v[sel]), 32'(e <= w));
      if (done_v[sel]) begin
        done_cnt++;
        done_e = e;
      end
      if (e == w) begin
        check($sformatf("bcd_hold s%0d v%0d", sel, val), 32'(bcd_of(sel)), 32'(prev_bcd[sel]));
        check($sformatf("ovf_hold s%0d v%0d", sel, val), 32'(ovf_v[sel]), 32'(prev_ovf[sel]));
      end
      if (e == 0) begin
        start_v[sel] = 1'b0;
        bin_v = 16'($urandom);
      end
      if (e == ign_e) begin
        start_v[sel] = 1'b1;
        bin_v = 16'(ign_val);
      end else if (e == ign_e + 1) begin
        start_v[sel] = 1'b0;
      end
    end
    check($sformatf("done_cnt s%0d v%0d", sel, val), 32'(done_cnt), 32'd1);
    check($sformatf("done_edge s%0d v%0d", sel, val), 32'(done_e), 32'(w + 1));
    check($sformatf("bcd s%0d v%0d", sel, val), 32'(bcd_of(sel)), 32'(exp_b));
    check($sformatf("ovf s%0d v%0d", sel, val), 32'(ovf_v[sel]), 32'(exp_o));
    prev_bcd[sel] = exp_b;
    prev_ovf[sel] = exp_o;
  endtask

  initial begin
    int dcnt;
    rst_n   = 1'b0;
    start_v = 4'b0000;
    bin_v   = 16'h0000;
    for (int s = 0; s < 4; s++) begin
      prev_bcd[s] = 20'h0;
      prev_ovf[s] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("rst_busy s%0d", s), 32'(busy_v[s]), 32'd0);
      check($sformatf("rst_done s%0d", s), 32'(done_v[s]), 32'd0);
      check($sformatf("rst_bcd s%0d", s), 32'(bcd_of(s)), 32'd0);
      check($sformatf("rst_ovf s%0d", s), 32'(ovf_v[s]), 32'd0);
    end
    rst_n = 1'b1;

    run_conv(0, 255, -1, 0);
    for (int v = 0; v < 16; v++) run_conv(1, v, -1, 0);
    run_conv(2, 100, -1, 0);
    run_conv(2, 99, -1, 0);
    run_conv(2, 7, -1, 0);
    run_conv(2, 255, -1, 0);
    run_conv(2, 0, -1, 0);
    run_conv(0, 42, 3, 200);

    // start held high: second value accepted on the single IDLE cycle after done.
    dcnt = 0;
    @(negedge clk);
    bin_v = 16'd77;
    start_v[0] = 1'b1;
    for (int e = 0; e <= 21; e++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) dcnt++;
      if (e == 9) begin
        check("b2b_first_bcd", 32'(bcd0), 32'h077);
        check("b2b_gap_busy", 32'(busy_v[0]), 32'd0);
      end
      if (e == 10) check("b2b_accept_busy", 32'(busy_v[0]), 32'd1);
      if (e == 19) begin
        check("b2b_second_done", 32'(done_v[0]), 32'd1);
        check("b2b_second_bcd", 32'(bcd0), 32'h201);
      end
      if (e == 0) bin_v = 16'd201;
      if (e == 10) start_v[0] = 1'b0;
    end
    check("b2b_done_cnt", 32'(dcnt), 32'd2);
    prev_bcd[0] = 20'h00201;
    prev_ovf[0] = 1'b0;

    // Reset in the middle of a conversion discards it.
    @(negedge clk);
    bin_v = 16'd123;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_done", 32'(done_v[0]), 32'd0);
    check("midrst_bcd", 32'(bcd0), 32'd0);
    check("midrst_ovf", 32'(ovf_v[0]), 32'd0);
    for (int s = 0; s < 4; s++) begin
      prev_bcd[s] = 20'h0;
      prev_ovf[s] = 1'b0;
    end
    dcnt = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) dcnt++;
    end
    check("midrst_no_done", 32'(dcnt), 32'd0);
    run_conv(0, 123, -1, 0);

    run_conv(3, 65535, -1, 0);
    run_conv(3, 0, -1, 0);

    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        run_conv(s, int'($urandom_range(0, (1 << width_of(s)) - 1)), -1, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
